// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise AND/OR/XOR/NOR unit: processes CHUNK bits per cycle, LSB first,
// with valid/ready handshakes on both sides and a registered zero flag.
module logic_unit_seq #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [1:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic             zero
);
   localparam int N  = WIDTH / CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_a, r_b, r_res;
   logic [1:0]       r_op;
   logic             r_zero;

   logic [CHUNK-1:0] w_a_sl, w_b_sl, w_slice;
   logic [WIDTH-1:0] w_res_nxt;
   logic             w_last;

   // Constant-index mux keeps slice selection lint-clean for any CHUNK/WIDTH pair
   always_comb begin
      w_a_sl = '0;
      w_b_sl = '0;
      for (int i = 0; i < N; i++) begin
         if (r_cnt == CW'(i)) begin
            w_a_sl = r_a[i*CHUNK +: CHUNK];
            w_b_sl = r_b[i*CHUNK +: CHUNK];
         end
      end
   end

   always_comb begin
      w_slice = '0;
      case (r_op)
         2'b00:   w_slice = w_a_sl & w_b_sl;
         2'b01:   w_slice = w_a_sl | w_b_sl;
         2'b10:   w_slice = w_a_sl ^ w_b_sl;
         default: w_slice = ~(w_a_sl | w_b_sl);
      endcase
   end

   always_comb begin
      w_res_nxt = r_res;
      for (int i = 0; i < N; i++) begin
         if (r_cnt == CW'(i)) w_res_nxt[i*CHUNK +: CHUNK] = w_slice;
      end
   end

   assign w_last = (r_cnt == CW'(N - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_op    <= '0;
         r_res   <= '0;
         r_zero  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a     <= A;
                  r_b     <= B;
                  r_op    <= op;
                  r_res   <= '0;
                  r_cnt   <= '0;
                  r_state <= S_BUSY;
               end
            end
            S_BUSY: begin
               r_res <= w_res_nxt;
               if (w_last) begin
                  r_cnt   <= '0;
                  // Flag computed from the fully assembled next result so it is valid with out_valid
                  r_zero  <= (w_res_nxt == '0);
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_zero  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign res       = r_res;
   assign zero      = r_zero;
endmodule

// File: tb/tb_logic_unit_seq.sv
// Bench for logic_unit_seq: table-driven vectors on a 32/8 instance with a result
// scoreboard, hand-written backpressure/reset sequences, and a randomized parameter sweep.
module tb_logic_unit_seq;
   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_res;
      logic        exp_zero;
   } vec_t;

   typedef struct {
      logic [63:0] res;
      logic        zero;
   } exp_t;

   int n_chk  = 0;
   int n_fail = 0;

   logic        clk;
   logic        rst_n = 1'b1;
   logic        m_in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] m_a = '0;
   logic [31:0] m_b = '0;
   logic [1:0]  m_op = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] res;
   logic        zero;

   exp_t q[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   logic_unit_seq #(.WIDTH(32), .CHUNK(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(in_ready),
      .A(m_a), .B(m_b), .op(m_op), .out_valid(out_valid), .out_ready(out_ready),
      .res(res), .zero(zero)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] gold(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
      case (o)
         2'b00:   return a & b;
         2'b01:   return a | b;
         2'b10:   return a ^ b;
         default: return ~(a | b);
      endcase
   endfunction

   // One transaction on the 32/8 instance; hold = cycles of out_ready low after out_valid,
   // scr = scramble inputs (and hold in_valid high) while busy.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ez, input int hold, input bit scr);
      exp_t        e;
      int          cyc;
      logic [31:0] r0;
      @(negedge clk);
      chk("in_ready_idle", in_ready, 1);
      m_op = o; m_a = a; m_b = b; m_in_valid = 1'b1;
      out_ready = (hold == 0);
      q.push_back('{64'(er), ez});
      @(negedge clk);
      chk("accepted", in_ready, 0);
      if (scr) begin
         m_a = ~a; m_b = b ^ 32'h5A5A_A5A5; m_op = o + 2'd1;
      end else begin
         m_in_valid = 1'b0;
      end
      cyc = 0;
      while (!out_valid && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      m_in_valid = 1'b0;
      chk("latency", 64'(cyc), 64'd4);
      e = q.pop_front();
      chk("res", 64'(res), e.res);
      chk("zero", zero, e.zero);
      r0 = res;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_res_stable", res, r0);
         chk("bp_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("out_valid_fall", out_valid, 0);
      chk("in_ready_back", in_ready, 1);
      chk("zero_idle", zero, 0);
      chk("res_hold_idle", res, r0);
   endtask

   // Parameter sweep: (32,1), (32,32), (64,16), each with its own reset and scoreboard
   for (genvar g = 0; g < 3; g++) begin : g_sw
      localparam int W  = (g == 2) ? 64 : 32;
      localparam int C  = (g == 0) ? 1 : ((g == 1) ? 32 : 16);
      localparam int NN = W / C;
      logic         s_rst_n = 1'b0;
      logic         s_iv = 1'b0;
      logic         s_ir, s_ov, s_z;
      logic         s_or = 1'b1;
      logic [W-1:0] s_a = '0;
      logic [W-1:0] s_b = '0;
      logic [W-1:0] s_r;
      logic [1:0]   s_op = '0;
      logic         done = 1'b0;
      exp_t         sq[$];

      logic_unit_seq #(.WIDTH(W), .CHUNK(C)) u_sw (
         .clk(clk), .rst_n(s_rst_n), .in_valid(s_iv), .in_ready(s_ir),
         .A(s_a), .B(s_b), .op(s_op), .out_valid(s_ov), .out_ready(s_or),
         .res(s_r), .zero(s_z)
      );

      initial begin : drv
         logic [63:0] ra, rb, g64;
         logic [W-1:0] ew;
         int cyc, hold;
         exp_t e;
         repeat (2) @(negedge clk);
         s_rst_n = 1'b1;
         for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if ($urandom_range(7) == 0) rb = ra;
            s_op = 2'($urandom_range(3));
            g64 = gold(s_op, ra, rb);
            ew = g64[W-1:0];
            sq.push_back('{64'(ew), (ew == '0)});
            hold = $urandom_range(2);
            s_a = ra[W-1:0]; s_b = rb[W-1:0]; s_iv = 1'b1; s_or = (hold == 0);
            chk("sweep_in_ready", s_ir, 1);
            @(negedge clk);
            s_iv = 1'b0;
            cyc = 0;
            while (!s_ov && cyc < NN + 10) begin
               @(negedge clk);
               cyc++;
            end
            chk("sweep_latency", 64'(cyc), 64'(NN));
            e = sq.pop_front();
            chk("sweep_res", 64'(s_r), e.res);
            chk("sweep_zero", s_z, e.zero);
            repeat (hold) @(negedge clk);
            s_or = 1'b1;
            @(negedge clk);
         end
         done = 1'b1;
      end
   end

   vec_t vecs[7];

   initial begin
      vecs[0] = '{2'b01, 32'hF0F0_0000, 32'h0F0F_00FF, 32'hFFFF_00FF, 1'b0};
      vecs[1] = '{2'b10, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1};
      vecs[2] = '{2'b11, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
      vecs[3] = '{2'b00, 32'h1234_5678, 32'h0000_FFFF, 32'h0000_5678, 1'b0};
      vecs[4] = '{2'b11, 32'hFFFF_0000, 32'h0000_FFFF, 32'h0000_0000, 1'b1};
      vecs[5] = '{2'b10, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 1'b0};
      vecs[6] = '{2'b00, 32'h8000_0001, 32'h8000_0000, 32'h8000_0000, 1'b0};

      // Asynchronous reset, checked before the first clock edge at t=5
      #1 rst_n = 1'b0;
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_res", res, 0);
      chk("rst_zero", zero, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++)
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].exp_zero, 0, 1'b0);

      // Backpressure with inputs scrambled during BUSY
      run_op(vecs[0].op, vecs[0].a, vecs[0].b, vecs[0].exp_res, vecs[0].exp_zero, 10, 1'b1);
      run_op(vecs[3].op, vecs[3].a, vecs[3].b, vecs[3].exp_res, vecs[3].exp_zero, 3, 1'b1);

      // Reset while BUSY with cnt == 2
      @(negedge clk);
      m_op = 2'b11; m_a = '0; m_b = '0; m_in_valid = 1'b1; out_ready = 1'b1;
      q.push_back('{64'hFFFF_FFFF, 1'b0});
      @(negedge clk);
      m_in_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("mid_busy_partial", res, 32'h0000_FFFF);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_in_ready", in_ready, 1);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_res", res, 0);
      chk("abort_zero", zero, 0);
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("no_stale_valid", out_valid, 0);
      end
      run_op(2'b01, 32'h1, 32'h2, 32'h0000_0003, 1'b0, 0, 1'b0);

      for (int i = 0; i < 60000 && !(g_sw[0].done && g_sw[1].done && g_sw[2].done); i++)
         @(negedge clk);
      chk("sweep_done", {g_sw[2].done, g_sw[1].done, g_sw[0].done}, 3'b111);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
